// File: rtl/dsdmnist_pkg.sv
// Shared widths, int8 limits and per-beat config bundle
// for the MNIST requantizer.
package dsdmnist_pkg;

  localparam int ACC_W   = 32;
  localparam int SCALE_W = 24;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 6;

  localparam int OUT_MAX = 127;
  localparam int OUT_MIN = -128;

  typedef struct packed {
    logic signed [ACC_W-1:0] bias;
    logic [SCALE_W-1:0]      scale;
    logic [SHIFT_W-1:0]      shift;
    logic                    relu;
  } requant_cfg_t;

endpackage

// File: rtl/dsdmnist_sat.sv
// Signed saturating narrower, combinational.
// Ports: din (IN_W signed) -> dout (OUT_W signed, clamped).
module dsdmnist_sat #(
  parameter int IN_W  = 33,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  logic [IN_W-OUT_W:0] top;
  logic                ovf;

  always_comb begin
    top = din[IN_W-1:OUT_W-1];
    // in range only when all dropped bits match the new sign bit
    ovf = !((&top) || !(|top));
    if (!ovf)
      dout = din[OUT_W-1:0];
    else if (din[IN_W-1])
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    else
      dout = {1'b0, {(OUT_W-1){1'b1}}};
  end

endmodule

// File: rtl/dsdmnist_requant.sv
// Bias add, scale/round-shift requant, ReLU and int8 saturation.
// Ports: valid/ready in (acc + per-beat cfg), valid/ready out, beat counter.
import dsdmnist_pkg::*;

module dsdmnist_requant #(
  parameter int ACCW   = ACC_W,
  parameter int SCALEW = SCALE_W,
  parameter int OUTW   = OUT_W,
  parameter int CNTW   = 10
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_IN_VALID,
  output logic                     o_IN_READY,
  input  logic signed [ACCW-1:0]   i_ACC,
  input  logic signed [ACCW-1:0]   i_BIAS,
  input  logic [SCALEW-1:0]        i_SCALE,
  input  logic [SHIFT_W-1:0]       i_SHIFT,
  input  logic                     i_RELU,
  output logic                     o_VALID,
  input  logic                     i_READY,
  output logic signed [OUTW-1:0]   o_DATA,
  input  logic                     i_CNT_CLR,
  output logic [CNTW-1:0]          o_CNT
);

  localparam int PRODW = ACCW + SCALEW + 1;
  localparam int RNDW  = PRODW + 1;
  // |prod| <= 2^(PRODW-2), so any shift >= PRODW rounds to 0;
  // clamping keeps the rounding constant inside RNDW bits
  localparam logic [SHIFT_W-1:0] SH_MAX = SHIFT_W'(PRODW);

  logic advance;
  assign advance    = !o_VALID || i_READY;
  assign o_IN_READY = advance;

  requant_cfg_t cfg_in;
  assign cfg_in = '{
    bias:  i_BIAS,
    scale: i_SCALE,
    shift: i_SHIFT,
    relu:  i_RELU
  };

  logic v1, v2, v3;

  (* use_dsp = "yes" *) logic signed [ACCW-1:0] sum1;
  (* use_dsp = "no" *)  logic [SCALEW-1:0]      scale1;
  (* use_dsp = "no" *)  logic [SHIFT_W-1:0]     shift1;
  (* use_dsp = "no" *)  logic                   relu1;

  (* use_dsp = "yes" *) logic signed [PRODW-1:0] prod2;
  (* use_dsp = "no" *)  logic [SHIFT_W-1:0]      shift2;
  (* use_dsp = "no" *)  logic                    relu2;

  (* use_dsp = "no" *)  logic signed [RNDW-1:0]  r3;
  (* use_dsp = "no" *)  logic                    relu3;

  logic signed [ACCW:0]    sum_wide;
  logic signed [ACCW-1:0]  sum_sat;
  logic signed [PRODW-1:0] prod_c;
  logic [SHIFT_W-1:0]      sh_eff;
  logic signed [RNDW-1:0]  ext;
  logic signed [RNDW-1:0]  half;
  logic signed [RNDW-1:0]  rsum;
  logic signed [RNDW-1:0]  rnd;
  logic signed [RNDW-1:0]  relu_val;
  logic signed [OUTW-1:0]  data_c;

  assign sum_wide = {i_ACC[ACCW-1], i_ACC}
                  + {cfg_in.bias[ACCW-1], cfg_in.bias};

  dsdmnist_sat #(
    .IN_W (ACCW+1),
    .OUT_W(ACCW)
  ) u_sat_s1 (
    .din (sum_wide),
    .dout(sum_sat)
  );

  assign prod_c = PRODW'(sum1)
                * PRODW'($signed({1'b0, scale1}));

  always_comb begin
    sh_eff = (shift2 > SH_MAX) ? SH_MAX : shift2;
    ext    = {prod2[PRODW-1], prod2};
    half   = '0;
    rsum   = ext;
    rnd    = ext;
    if (sh_eff != '0) begin
      half = RNDW'(1) << (sh_eff - 1'b1);
      rsum = ext + half;
      rnd  = rsum >>> sh_eff;
    end
  end

  assign relu_val = (relu3 && r3[RNDW-1]) ? '0 : r3;

  dsdmnist_sat #(
    .IN_W (RNDW),
    .OUT_W(OUTW)
  ) u_sat_s4 (
    .din (relu_val),
    .dout(data_c)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      o_VALID <= 1'b0;
      o_DATA  <= '0;
    end else if (advance) begin
      v1      <= i_IN_VALID;
      v2      <= v1;
      v3      <= v2;
      o_VALID <= v3;
      if (v3)
        o_DATA <= data_c;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (advance) begin
      sum1   <= sum_sat;
      scale1 <= cfg_in.scale;
      shift1 <= cfg_in.shift;
      relu1  <= cfg_in.relu;
      prod2  <= prod_c;
      shift2 <= shift1;
      relu2  <= relu1;
      r3     <= rnd;
      relu3  <= relu2;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST)
      o_CNT <= '0;
    else if (i_CNT_CLR)
      o_CNT <= '0;
    else if (o_VALID && i_READY)
      o_CNT <= o_CNT + CNTW'(1);
  end

endmodule

// File: tb/tb_dsdmnist_requant.sv
// Self-checking bench for dsdmnist_requant: table vectors,
// hand sequences and random beats against an arithmetic model.
import dsdmnist_pkg::*;

module tb_dsdmnist_requant;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] acc = '0;
  logic [31:0] bias = '0;
  logic [23:0] scale = '0;
  logic [5:0]  shift = '0;
  logic        relu = 1'b0;
  logic        o_valid;
  logic        ready = 1'b1;
  logic [7:0]  o_data;
  logic        cnt_clr = 1'b0;
  logic [9:0]  o_cnt;

  int total = 0;
  int bad = 0;
  logic [7:0] expq[$];
  logic [9:0] exp_cnt = '0;

  always #5 clk = ~clk;

  dsdmnist_requant dut (
    .i_CLK     (clk),
    .i_RST     (rst),
    .i_IN_VALID(in_valid),
    .o_IN_READY(in_ready),
    .i_ACC     (acc),
    .i_BIAS    (bias),
    .i_SCALE   (scale),
    .i_SHIFT   (shift),
    .i_RELU    (relu),
    .o_VALID   (o_valid),
    .i_READY   (ready),
    .o_DATA    (o_data),
    .i_CNT_CLR (cnt_clr),
    .o_CNT     (o_cnt)
  );

  function automatic logic [7:0] model(
    input logic [31:0] a, input logic [31:0] b,
    input logic [23:0] sc, input logic [5:0] sh,
    input logic rl);
    longint s, p, r, av, bv, scv, one;
    av  = $signed(a);
    bv  = $signed(b);
    scv = sc;
    s = av + bv;
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    p = s * scv;
    one = 1;
    if (sh == 0) r = p;
    else r = (p + (one << (sh - 1))) >>> sh;
    if (rl && r < 0) r = 0;
    if (r > OUT_MAX) r = OUT_MAX;
    if (r < OUT_MIN) r = OUT_MIN;
    return r[7:0];
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = '0;
    end else begin
      if (o_valid && ready) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL stray_beat got=%0h exp=none", o_data);
        end else begin
          logic [7:0] e;
          e = expq.pop_front();
          if (o_data !== e) begin
            bad++;
            $display("FAIL out_data got=%0h exp=%0h", o_data, e);
          end
        end
      end
      if (cnt_clr) exp_cnt = '0;
      else if (o_valid && ready) exp_cnt = exp_cnt + 10'd1;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [23:0] sc, input logic [5:0] sh,
                      input logic rl, input logic [7:0] e);
    logic ok, rdy;
    ok = 1'b0;
    in_valid = 1'b1;
    acc = a; bias = b; scale = sc; shift = sh; relu = rl;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (ok) expq.push_back(e);
    else begin
      total++; bad++;
      $display("FAIL send_timeout got=0 exp=1");
    end
  endtask

  task automatic send_rand();
    logic [31:0] a, b;
    logic [23:0] sc;
    logic [5:0]  sh;
    logic        rl;
    a  = $urandom;
    if ($urandom_range(0, 1) == 1) a = 32'($signed(a) >>> 12);
    b  = 32'($signed($urandom) >>> $urandom_range(8, 24));
    sc = 24'($urandom);
    if ($urandom_range(0, 3) == 0) sh = 6'($urandom_range(0, 63));
    else sh = 6'($urandom_range(24, 50));
    rl = 1'($urandom_range(0, 1));
    send(a, b, sc, sh, rl, model(a, b, sc, sh, rl));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got=%0d exp=0", expq.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [23:0] sc;
    logic [5:0]  sh;
    logic        rl;
    logic [7:0]  e;
  } vec_t;

  vec_t vt[10];

  initial begin
    int n;
    logic [7:0] held;
    logic done;

    vt[0] = '{32'd1000, 32'd24, 24'h800000, 6'd30, 1'b0, 8'd8};
    vt[1] = '{32'd6, 32'd0, 24'd1, 6'd2, 1'b0, 8'd2};
    vt[2] = '{32'd5, 32'd0, 24'd1, 6'd2, 1'b0, 8'd1};
    vt[3] = '{-32'sd500, 32'd0, 24'd1, 6'd2, 1'b0, 8'h83};
    vt[4] = '{-32'sd500, 32'd0, 24'd1, 6'd2, 1'b1, 8'h00};
    vt[5] = '{32'h7FFFFFF0, 32'h100, 24'd1, 6'd0, 1'b0, 8'h7F};
    vt[6] = '{32'h80000000, 32'hFFFFFFFF, 24'd1, 6'd0, 1'b0, 8'h80};
    vt[7] = '{-32'sd6, 32'd0, 24'd1, 6'd2, 1'b0, 8'hFF};
    vt[8] = '{-32'sd10, 32'd0, 24'hFFFFFF, 6'd63, 1'b0, 8'h00};
    vt[9] = '{32'd100, 32'd0, 24'd3, 6'd1, 1'b0, 8'h7F};

    do_reset();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_cnt", 32'(o_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // latency: accept on edge 1, o_VALID after edge 4
    in_valid = 1'b1;
    acc = vt[0].a; bias = vt[0].b; scale = vt[0].sc;
    shift = vt[0].sh; relu = vt[0].rl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expq.push_back(vt[0].e);
    n = 1;
    while (!o_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    drain();

    foreach (vt[i])
      send(vt[i].a, vt[i].b, vt[i].sc, vt[i].sh, vt[i].rl, vt[i].e);
    drain();

    // streaming with a 3-cycle output stall
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'(i), 32'd0, 24'd1, 6'd0, 1'b0, 8'(i));
      end
      begin
        n = 0;
        while (!o_valid && n < 50) begin
          @(posedge clk);
          #1;
          n++;
        end
        @(posedge clk);
        #1;
        ready = 1'b0;
        held = o_data;
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("hold_in_ready", 32'(in_ready), 32'd0);
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_data", 32'(o_data), 32'(held));
        end
        ready = 1'b1;
      end
    join
    drain();
    chk("stream_cnt", 32'(o_cnt), 32'd8);

    // reset with three beats in flight
    for (int i = 0; i < 3; i++)
      send(32'(i + 20), 32'd0, 24'd1, 6'd0, 1'b0, 8'(i + 20));
    rst = 1'b1;
    expq.delete();
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_cnt", 32'(o_cnt), 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrst_quiet", 32'(o_valid), 32'd0);

    // random beats with random backpressure; counter reaches 1023
    fork
      begin
        for (int i = 0; i < 1023; i++) send_rand();
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          ready = ($urandom_range(0, 3) != 0);
        end
        ready = 1'b1;
      end
    join
    drain();
    chk("cnt_1023", 32'(o_cnt), 32'd1023);
    chk("cnt_model", 32'(o_cnt), 32'(exp_cnt));
    send_rand();
    drain();
    chk("cnt_wrap", 32'(o_cnt), 32'd0);

    // clear coincident with a transfer
    send_rand();
    send_rand();
    drain();
    chk("cnt_two", 32'(o_cnt), 32'd2);
    send(32'd3, 32'd0, 24'd1, 6'd0, 1'b0, 8'd3);
    n = 0;
    while (!o_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clr_valid", 32'(o_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    chk("clr_wins", 32'(o_cnt), 32'd0);
    chk("clr_queue", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
